// File: rtl/urv_iram_loader_if.sv
// Host-link and IRAM port-B bundle for the urv program loader.
// master = loader side, slave = host link plus IRAM side.
interface urv_iram_loader_if;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        enb_o;
    logic        web_o;
    logic [31:0] ab_o;
    logic [3:0]  bweb_o;
    logic [31:0] db_o;
    logic [31:0] qb_i;

    // Both links are valid/ready: a byte moves on a rising clk_i edge where
    // valid and ready are both high; the sender holds data stable until then.
    modport master (
        input  rx_data_i, rx_valid_i, tx_ready_i, qb_i,
        output rx_ready_o, tx_data_o, tx_valid_o,
        output enb_o, web_o, ab_o, bweb_o, db_o
    );
    modport slave (
        output rx_data_i, rx_valid_i, tx_ready_i, qb_i,
        input  rx_ready_o, tx_data_o, tx_valid_o,
        input  enb_o, web_o, ab_o, bweb_o, db_o
    );
endinterface

// File: rtl/urv_iram_loader.sv
// Host-driven IRAM loader: byte commands A/W/R/G/H fill, read back and release the core.
// Optional URV_LOADER_CHECKSUM_EN adds a write-data byte sum returned by command 'S'.
module urv_iram_loader #(
    parameter int g_size      = 65536,
    parameter bit g_hold_core = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    urv_iram_loader_if.master      bus,
    output logic                   cpu_rst_o,
    output logic                   busy_o,
    output logic [2:0]             dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARG    = 3'd1,
        WRITE  = 3'd2,
        RD_REQ = 3'd3,
        RD_CAP = 3'd4,
        TX     = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_A = 8'h41;
    localparam logic [7:0]  CMD_W = 8'h57;
    localparam logic [7:0]  CMD_R = 8'h52;
    localparam logic [7:0]  CMD_G = 8'h47;
    localparam logic [7:0]  CMD_H = 8'h48;
    localparam logic [7:0]  RSP_OK  = 8'h4B;
    localparam logic [7:0]  RSP_BAD = 8'h3F;
    localparam logic [31:0] PTR_MASK = 32'(g_size - 1) & 32'hFFFF_FFFC;

    state_t      state;
    logic [7:0]  cmd;
    logic [1:0]  cnt;
    logic [31:0] word;
    logic [31:0] ptr;
    logic [31:0] tx_word;
    logic [1:0]  tx_cnt;
    logic [1:0]  tx_last;
    logic        rx_fire;
    logic        tx_fire;
`ifdef URV_LOADER_CHECKSUM_EN
    localparam logic [7:0] CMD_S = 8'h53;
    logic [7:0] sum;
`endif

    assign rx_fire   = bus.rx_valid_i & bus.rx_ready_o;
    assign tx_fire   = bus.tx_valid_o & bus.tx_ready_i;
    assign dbg_state = state;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            cmd            <= '0;
            cnt            <= '0;
            word           <= '0;
            ptr            <= '0;
            tx_word        <= '0;
            tx_cnt         <= '0;
            tx_last        <= '0;
            bus.rx_ready_o <= 1'b0;
            bus.tx_data_o  <= '0;
            bus.tx_valid_o <= 1'b0;
            bus.enb_o      <= 1'b0;
            bus.web_o      <= 1'b0;
            bus.ab_o       <= '0;
            bus.bweb_o     <= '0;
            bus.db_o       <= '0;
            cpu_rst_o      <= g_hold_core;
            busy_o         <= 1'b0;
`ifdef URV_LOADER_CHECKSUM_EN
            sum            <= '0;
`endif
        end else begin
            bus.enb_o  <= 1'b0;
            bus.web_o  <= 1'b0;
            bus.bweb_o <= '0;
            case (state)
                IDLE: begin
                    bus.rx_ready_o <= 1'b1;
                    busy_o         <= 1'b0;
                    if (rx_fire) begin
                        cmd    <= bus.rx_data_i;
                        busy_o <= 1'b1;
                        // Single-byte responses reuse the TX state with tx_last = 0.
                        tx_cnt  <= '0;
                        tx_last <= '0;
                        case (bus.rx_data_i)
                            CMD_A, CMD_W: begin
                                state <= ARG;
                                cnt   <= '0;
                            end
                            CMD_R: begin
                                state          <= RD_REQ;
                                bus.rx_ready_o <= 1'b0;
                                bus.enb_o      <= 1'b1;
                                bus.ab_o       <= ptr;
                            end
                            CMD_G, CMD_H: begin
                                cpu_rst_o      <= (bus.rx_data_i == CMD_H);
                                state          <= TX;
                                bus.rx_ready_o <= 1'b0;
                                bus.tx_data_o  <= RSP_OK;
                                bus.tx_valid_o <= 1'b1;
                            end
`ifdef URV_LOADER_CHECKSUM_EN
                            CMD_S: begin
                                state          <= TX;
                                bus.rx_ready_o <= 1'b0;
                                bus.tx_data_o  <= sum;
                                bus.tx_valid_o <= 1'b1;
                            end
`endif
                            default: begin
                                state          <= TX;
                                bus.rx_ready_o <= 1'b0;
                                bus.tx_data_o  <= RSP_BAD;
                                bus.tx_valid_o <= 1'b1;
                            end
                        endcase
                    end
                end
                ARG: begin
                    if (rx_fire) begin
                        word <= {word[23:0], bus.rx_data_i};
                        cnt  <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (cmd == CMD_A) begin
                                ptr    <= {word[23:0], bus.rx_data_i} & PTR_MASK;
                                state  <= IDLE;
                                busy_o <= 1'b0;
`ifdef URV_LOADER_CHECKSUM_EN
                                sum    <= '0;
`endif
                            end else begin
                                state          <= WRITE;
                                bus.rx_ready_o <= 1'b0;
                                bus.enb_o      <= 1'b1;
                                bus.web_o      <= 1'b1;
                                bus.bweb_o     <= 4'hF;
                                bus.ab_o       <= ptr;
                                bus.db_o       <= {word[23:0], bus.rx_data_i};
`ifdef URV_LOADER_CHECKSUM_EN
                                sum <= sum + word[23:16] + word[15:8] + word[7:0]
                                       + bus.rx_data_i;
`endif
                            end
                        end
                    end
                end
                WRITE: begin
                    ptr            <= (ptr + 32'd4) & PTR_MASK;
                    state          <= IDLE;
                    bus.rx_ready_o <= 1'b1;
                    busy_o         <= 1'b0;
                end
                RD_REQ: state <= RD_CAP;
                RD_CAP: begin
                    tx_word        <= bus.qb_i;
                    bus.tx_data_o  <= bus.qb_i[31:24];
                    bus.tx_valid_o <= 1'b1;
                    tx_cnt         <= '0;
                    tx_last        <= 2'd3;
                    ptr            <= (ptr + 32'd4) & PTR_MASK;
                    state          <= TX;
                end
                TX: begin
                    if (tx_fire) begin
                        if (tx_cnt == tx_last) begin
                            bus.tx_valid_o <= 1'b0;
                            state          <= IDLE;
                            bus.rx_ready_o <= 1'b1;
                            busy_o         <= 1'b0;
                        end else begin
                            tx_cnt        <= tx_cnt + 2'd1;
                            bus.tx_data_o <= tx_word[23:16];
                            tx_word       <= {tx_word[23:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.rx_ready_o <= 1'b0;
                    bus.tx_valid_o <= 1'b0;
                    busy_o         <= 1'b0;
                end
            endcase
        end
    end
endmodule
